// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   NOP_INSTR    : canonical RV32 NOP (addi x0, x0, 0) used for bubbles
//   fetchState_t : request-tracking state (IDLE / WAIT / STALE)
//   ifId_t       : contents of the IF/ID pipeline register
//   alignWord    : forces an address onto a 32-bit word boundary
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no request outstanding
        WAIT  = 2'd1,   // one request outstanding, response wanted
        STALE = 2'd2    // one request outstanding, response to be dropped
    } fetchState_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
    } ifId_t;

    function automatic logic [31:0] alignWord(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// One-entry holding register for a fetched instruction that IF/ID could not
// accept in the cycle it arrived.
//   clk, rst_n          : clock, asynchronous active-low reset
//   load                : capture {loadPc, loadInstr}
//   clear               : discard the entry (redirect); wins over load/drain
//   drain               : entry consumed this cycle
//   loadPc, loadInstr   : entry to capture
//   bufValid            : entry present
//   bufPc, bufInstr     : held entry
module fetch_buffer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        clear,
    input  logic        drain,
    input  logic [31:0] loadPc,
    input  logic [31:0] loadInstr,
    output logic        bufValid,
    output logic [31:0] bufPc,
    output logic [31:0] bufInstr
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bufValid <= 1'b0;
            bufPc    <= '0;
            bufInstr <= '0;
        end else if (clear) begin
            bufValid <= 1'b0;
        end else if (load) begin
            bufValid <= 1'b1;
            bufPc    <= loadPc;
            bufInstr <= loadInstr;
        end else if (drain) begin
            bufValid <= 1'b0;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the pipelined RV32 core. Owns the PC, issues single-word
// requests over a valid/ready handshake, buffers one response and drives
// the IF/ID pipeline register under hazard-unit control.
//   clk, rst_n                       : clock, asynchronous active-low reset
//   pc_write                         : 0 blocks new requests (load-use stall)
//   if_id_write                      : 0 holds IF/ID
//   if_flush                         : loads a bubble into IF/ID
//   pc_src, branch_target            : redirect and its target
//   imem_req_valid/addr/ready        : instruction memory request channel
//   imem_rsp_valid/data              : instruction memory response strobe
//   if_id_pc/instr/valid             : IF/ID pipeline register
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pc_write,
    input  logic        if_id_write,
    input  logic        if_flush,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    fetchState_t state, stateNext;
    logic [31:0] fetchPc;
    logic [31:0] reqPc;
    ifId_t       ifIdReg, ifIdNext;

    logic        bufValid;
    logic [31:0] bufPc;
    logic [31:0] bufInstr;
    logic        bufLoad, bufClear, bufDrain;

    logic        liveRsp;
    logic        ifIdAdvance;
    logic        slotFree;
    logic        issueWindow;
    logic        accept;

    // A response is only live when it belongs to the current stream; a
    // redirect in the same cycle drops it.
    assign liveRsp     = (state == WAIT) && imem_rsp_valid && !pc_src;

    // Whatever is presented to IF/ID leaves the stage this cycle: either it
    // is written, or a flush discards it.
    assign ifIdAdvance = if_id_write || if_flush;

    // Issuing only when the buffer will be empty at the end of the cycle
    // keeps the invariant "request outstanding => buffer empty", so a
    // returning response always has somewhere to go.
    assign slotFree    = ifIdAdvance || !(bufValid || liveRsp);
    assign issueWindow = (state == IDLE) || ((state == WAIT) && imem_rsp_valid);

    assign imem_req_valid = issueWindow && pc_write && !pc_src && slotFree;
    assign imem_req_addr  = fetchPc;
    assign accept         = imem_req_valid && imem_req_ready;

    assign bufLoad  = liveRsp && !ifIdAdvance;
    assign bufClear = pc_src;
    assign bufDrain = bufValid && ifIdAdvance;

    fetch_buffer uBuffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (bufLoad),
        .clear     (bufClear),
        .drain     (bufDrain),
        .loadPc    (reqPc),
        .loadInstr (imem_rsp_data),
        .bufValid  (bufValid),
        .bufPc     (bufPc),
        .bufInstr  (bufInstr)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    stateNext = pc_src ? STALE : WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    stateNext = accept ? WAIT : IDLE;
                end else if (pc_src) begin
                    stateNext = STALE;
                end
            end
            STALE: begin
                if (imem_rsp_valid) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        ifIdNext = ifIdReg;
        if (if_flush) begin
            ifIdNext = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else if (!if_id_write) begin
            ifIdNext = ifIdReg;
        end else if (bufValid) begin
            ifIdNext = '{pc: bufPc, instr: bufInstr, valid: 1'b1};
        end else if (liveRsp) begin
            ifIdNext = '{pc: reqPc, instr: imem_rsp_data, valid: 1'b1};
        end else begin
            ifIdNext = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            fetchPc <= RESET_PC;
            reqPc   <= RESET_PC;
            ifIdReg <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
        end else begin
            state   <= stateNext;
            ifIdReg <= ifIdNext;
            if (accept) begin
                reqPc <= fetchPc;
            end
            if (pc_src) begin
                fetchPc <= alignWord(branch_target);
            end else if (accept) begin
                fetchPc <= fetchPc + 32'd4;
            end
        end
    end

    assign if_id_pc    = ifIdReg.pc;
    assign if_id_instr = ifIdReg.instr;
    assign if_id_valid = ifIdReg.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit. Inputs change 1 time unit after
// the rising edge; combinational request outputs are sampled 1 unit later,
// registered IF/ID outputs right after each edge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pc_write;
    logic        if_id_write;
    logic        if_flush;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    int unsigned totalCnt = 0;
    int unsigned badCnt   = 0;

    always #5 clk = ~clk;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_flush       (if_flush),
        .pc_src         (pc_src),
        .branch_target  (branch_target),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr),
        .if_id_valid    (if_id_valid)
    );

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        if (obs !== exp) begin
            badCnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkIfId(input string tag, input logic [31:0] pc,
                             input logic [31:0] instr, input logic valid);
        checkVal({tag, ".pc"},    if_id_pc,           pc);
        checkVal({tag, ".instr"}, if_id_instr,        instr);
        checkVal({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
    endtask

    task automatic checkReq(input string tag, input logic valid, input logic [31:0] addr);
        #1;
        checkVal({tag, ".rv"}, {31'd0, imem_req_valid}, {31'd0, valid});
        if (valid) checkVal({tag, ".ra"}, imem_req_addr, addr);
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        imem_rsp_valid = v;
        imem_rsp_data  = d;
    endtask

    initial begin
        rst_n = 1'b0; pc_write = 1'b1; if_id_write = 1'b1; if_flush = 1'b0;
        pc_src = 1'b0; branch_target = '0; imem_req_ready = 1'b0;
        rsp(1'b0, '0);
        cyc(); cyc();
        checkIfId("reset", 32'h0, NOP, 1'b0);
        rst_n = 1'b1;

        // zero-wait streaming
        imem_req_ready = 1'b1;
        checkReq("s0", 1'b1, 32'h0);
        cyc();
        rsp(1'b1, 32'hA000_0000);
        checkReq("s1", 1'b1, 32'h4);
        cyc();
        checkIfId("s1", 32'h0, 32'hA000_0000, 1'b1);
        rsp(1'b1, 32'hA000_0004);
        checkReq("s2", 1'b1, 32'h8);
        cyc();
        checkIfId("s2", 32'h4, 32'hA000_0004, 1'b1);
        rsp(1'b1, 32'hA000_0008);
        checkReq("s3", 1'b1, 32'hC);
        cyc();
        checkIfId("s3", 32'h8, 32'hA000_0008, 1'b1);

        // 3-cycle stall while the response for 0xC arrives
        if_id_write = 1'b0; pc_write = 1'b0;
        rsp(1'b1, 32'hA000_000C);
        checkReq("st0", 1'b0, 32'h0);
        cyc();
        checkIfId("st0", 32'h8, 32'hA000_0008, 1'b1);
        rsp(1'b0, '0);
        checkReq("st1", 1'b0, 32'h0);
        cyc();
        checkReq("st2", 1'b0, 32'h0);
        cyc();
        checkIfId("st2", 32'h8, 32'hA000_0008, 1'b1);
        if_id_write = 1'b1; pc_write = 1'b1;
        checkReq("rel", 1'b1, 32'h10);
        cyc();
        checkIfId("rel", 32'hC, 32'hA000_000C, 1'b1);
        rsp(1'b1, 32'hA000_0010);
        checkReq("r1", 1'b1, 32'h14);
        cyc();
        checkIfId("r1", 32'h10, 32'hA000_0010, 1'b1);

        // redirect to 0x100 while 0x14 is outstanding, late stale response
        rsp(1'b0, '0);
        pc_src = 1'b1; if_flush = 1'b1; branch_target = 32'h0000_0100;
        checkReq("br", 1'b0, 32'h0);
        cyc();
        checkIfId("flush", 32'h0, NOP, 1'b0);
        pc_src = 1'b0; if_flush = 1'b0;
        checkReq("stale0", 1'b0, 32'h0);
        cyc();
        rsp(1'b1, 32'hDEAD_BEEF);
        checkReq("stale1", 1'b0, 32'h0);
        cyc();
        checkIfId("drop", 32'h0, NOP, 1'b0);
        rsp(1'b0, '0);
        checkReq("tgt", 1'b1, 32'h100);
        cyc();

        // memory not ready for 4 cycles
        imem_req_ready = 1'b0;
        rsp(1'b1, 32'hA000_0100);
        checkReq("nr0", 1'b1, 32'h104);
        cyc();
        checkIfId("nr0", 32'h100, 32'hA000_0100, 1'b1);
        rsp(1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            checkReq("nr", 1'b1, 32'h104);
            cyc();
        end
        imem_req_ready = 1'b1;
        checkReq("acc", 1'b1, 32'h104);
        cyc();
        rsp(1'b1, 32'hA000_0104);
        checkReq("once", 1'b1, 32'h108);
        cyc();
        checkIfId("once", 32'h104, 32'hA000_0104, 1'b1);

        // redirect with a same-cycle live response; unaligned target
        rsp(1'b1, 32'hA000_0108);
        pc_src = 1'b1; branch_target = 32'hFFFF_FFFF;
        checkReq("wbr", 1'b0, 32'h0);
        cyc();
        checkIfId("wdrop", 32'h0, NOP, 1'b0);
        pc_src = 1'b0;
        rsp(1'b0, '0);
        checkReq("w0", 1'b1, 32'hFFFF_FFFC);
        cyc();
        rsp(1'b1, 32'h1234_5678);
        checkReq("wrap", 1'b1, 32'h0);
        cyc();
        checkIfId("wrap", 32'hFFFF_FFFC, 32'h1234_5678, 1'b1);

        // reset while a request to 0x0 is outstanding
        rsp(1'b0, '0);
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        cyc();
        checkIfId("rst2", 32'h0, NOP, 1'b0);
        rst_n = 1'b1;
        rsp(1'b1, 32'hBAD0_BAD0);
        checkReq("rst2", 1'b1, 32'h0);
        cyc();
        checkIfId("ignore", 32'h0, NOP, 1'b0);
        rsp(1'b0, '0);
        imem_req_ready = 1'b1;
        checkReq("rst3", 1'b1, 32'h0);
        cyc();
        checkIfId("rst3", 32'h0, NOP, 1'b0);
        rsp(1'b1, 32'hA000_0000);
        cyc();
        checkIfId("rst4", 32'h0, 32'hA000_0000, 1'b1);

        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Fetch stage of the pipelined RV32 core. It owns the PC, issues single-word requests to instruction memory over a valid/ready handshake, and buffers one response. It drives the IF/ID pipeline register and obeys the stall, flush and redirect controls produced by the hazard detection unit (`pcWrite`, `ifIdWrite`, `IFflush`, `pcSrc`).

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address after reset.
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pc_write`  in  1  0 blocks issue of new requests (load-use stall).
- `if_id_write`  in  1  0 holds the IF/ID register.
- `if_flush`  in  1  1 loads a bubble into IF/ID; overrides `if_id_write`.
- `pc_src`  in  1  redirect taken this cycle.
- `branch_target`  in  32  redirect address; bits [1:0] are ignored and forced to 0.
- `imem_req_valid`  out  1  request offer; not sticky.
- `imem_req_addr`  out  32  word-aligned fetch address.
- `imem_req_ready`  in  1  memory accepts the request when valid&&ready.
- `imem_rsp_valid`  in  1  response strobe, one cycle, at least 1 cycle after accept.
- `imem_rsp_data`  in  32  instruction word.
- `if_id_pc`  out  32  PC of the instruction in IF/ID.
- `if_id_instr`  out  32  instruction in IF/ID.
- `if_id_valid`  out  1  0 means bubble.

## Operation
- `fetch_pc`: the address of the next request.
  - On accept (`imem_req_valid && imem_req_ready`): `req_pc <= fetch_pc` and `fetch_pc <= fetch_pc + 4`, wrapping mod 2^32.
- State machine:
  - IDLE: no request outstanding.
  - WAIT: one request outstanding, live.
  - STALE: one request outstanding, its response is to be dropped.
- Transitions:
  - IDLE -> WAIT on accept.
  - WAIT -> IDLE on `rsp_valid`, unless a new accept happens in the same cycle, which gives WAIT -> WAIT.
  - WAIT -> STALE on `pc_src` without `rsp_valid`.
  - STALE -> IDLE on `rsp_valid`; the data is discarded.
  - `pc_src` in IDLE while an accept is happening: that accept goes to STALE.
- `imem_req_valid` = (IDLE or (WAIT and `rsp_valid`)) and `pc_write` and !`pc_src` and slot_free.
  - slot_free: the buffer will be empty at the end of this cycle, i.e. whatever is presented to IF/ID this cycle is consumed (`if_id_write` = 1) or nothing is pending.
  - Invariant: an outstanding request implies the buffer is empty, so the buffer never overflows.
- Data path into IF/ID, evaluated in priority order:
  1. `if_flush`: IF/ID <= {pc 0, NOP 32'h0000_0013, valid 0}.
  2. `if_id_write` = 0: IF/ID holds.
  3. Buffer valid: IF/ID <= buffer, and the buffer clears.
  4. Live response (WAIT and `rsp_valid`): bypass directly, IF/ID <= {`req_pc`, `rsp_data`, 1}.
  5. Otherwise: bubble.
- A live response that is not consumed by IF/ID (stall) is written into the buffer.
- Redirect (`pc_src`):
  - `fetch_pc <= branch_target`.
  - The buffer clears.
  - A live response arriving in the same cycle is dropped.
  - No request issues in that cycle.
- Reset values:
  - State IDLE, `fetch_pc` = RESET_PC, buffer empty.
  - IF/ID = {0, NOP, 0}.
  - `imem_req_valid` goes high combinationally in the first cycle after reset (inputs permitting).
- Reset mid-operation: the outstanding request is forgotten, and any response after reset deasserts is ignored because the state is IDLE.

## Timing
- With zero-wait memory (ready = 1, response exactly 1 cycle after accept): accept in cycle N, response in N+1, IF/ID valid after the edge ending N+1.
  - Sustained throughput is 1 instruction/cycle, since the next request issues in N+1 alongside the response.
- A stall adds exactly the stall length; no instruction is lost or duplicated.
- Redirect in cycle N: the first request to the target is offered in N+1; IF/ID holds a bubble after the edge ending N if `if_flush` is asserted.
- `imem_req_valid` and `imem_req_addr` are combinational from state and inputs; every other output is registered.

## Structure
- Package `fetch_pkg`:
  - `NOP_INSTR` = 32'h0000_0013.
  - State enum (IDLE/WAIT/STALE).
  - IF/ID struct {pc, instr, valid}.
- Sub-module `fetch_buffer`: one-entry {pc, instr} holding register with load, clear and drain controls.
- PC, FSM and IF/ID register live in the top module.

## Test plan
- Reset, then ready = 1 with 1-cycle responses -> addresses 0, 4, 8, 12 accepted on consecutive cycles; IF/ID valid with PCs 0, 4, 8 on consecutive cycles.
- `if_id_write` = `pc_write` = 0 for 3 cycles while a response arrives -> the instruction is buffered, no new request issues, and IF/ID shows it on the first cycle after release; no PC skip.
- `pc_src` = 1 with `branch_target` 0x100 while in WAIT; the response arrives 2 cycles later -> the response is dropped, the next request is addressed 0x100, and IF/ID shows a bubble after flush.
- `imem_req_ready` = 0 for 4 cycles -> `imem_req_valid` stays high with a constant address; on accept, `fetch_pc` advances by 4 exactly once.
- `branch_target` 0xFFFF_FFFC followed by sequential fetch -> the next address is 0x0000_0000 (wrap).
- `rst_n` asserted while in WAIT, then a response after release -> the response is ignored, the first request is addressed to RESET_PC, and IF/ID stays {0, NOP, 0} until a valid fetch.
